// File: rtl/lane_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// lane_rr_arbiter_if
// Bundles the four lane inputs, the downstream handshake and the status
// outputs of lane_rr_arbiter so they travel as one port.
//
// Signals
//   data_0..data_3   lane payloads (8 bits each), driven by the lane sources
//   valid_0..valid_3 lane N payload present this cycle
//   out_ready        downstream accepts data_out this cycle
//   data_out         scheduled payload (8 bits)
//   valid_out        data_out holds an undelivered payload
//   grant            lane index of the payload in data_out (2 bits)
//   full_0..full_3   lane N holding register occupied
//   drop_cnt         saturating count of discarded lane payloads (8 bits)
//
// Modports
//   master  the side that drives the lanes and out_ready (sources/sink)
//   slave   the arbiter itself
// ---------------------------------------------------------------------------
interface lane_rr_arbiter_if;

    logic [7:0] data_0;
    logic [7:0] data_1;
    logic [7:0] data_2;
    logic [7:0] data_3;
    logic       valid_0;
    logic       valid_1;
    logic       valid_2;
    logic       valid_3;
    logic       out_ready;

    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] grant;
    logic       full_0;
    logic       full_1;
    logic       full_2;
    logic       full_3;
    logic [7:0] drop_cnt;

    modport master (
        output data_0, data_1, data_2, data_3,
        output valid_0, valid_1, valid_2, valid_3,
        output out_ready,
        input  data_out, valid_out, grant,
        input  full_0, full_1, full_2, full_3,
        input  drop_cnt
    );

    modport slave (
        input  data_0, data_1, data_2, data_3,
        input  valid_0, valid_1, valid_2, valid_3,
        input  out_ready,
        output data_out, valid_out, grant,
        output full_0, full_1, full_2, full_3,
        output drop_cnt
    );

endinterface

// File: rtl/lane_rr_arbiter.sv
// ---------------------------------------------------------------------------
// lane_rr_arbiter
// Four-lane round-robin arbiter. Each lane has a single-entry holding
// register; a registered output stage presents one held payload at a time
// to a ready/valid downstream. Payloads arriving at a lane whose holding
// register is occupied (and not being drained that cycle) are discarded and
// counted in a saturating drop counter.
//
// Ports
//   clk_f    in   rising-edge clock
//   reset_L  in   asynchronous active-low reset
//   bus      slave modport of lane_rr_arbiter_if (lane inputs, out_ready,
//            data_out/valid_out/grant, full_N flags, drop_cnt)
// ---------------------------------------------------------------------------
module lane_rr_arbiter (
    input  logic                clk_f,
    input  logic                reset_L,
    lane_rr_arbiter_if.slave    bus
);

    logic [3:0] lane_valid;
    logic [7:0] lane_data [4];

    logic [3:0] occ;
    logic [7:0] hold [4];
    logic [1:0] ptr;

    logic [7:0] data_out_r;
    logic       valid_out_r;
    logic [1:0] grant_r;
    logic [7:0] drop_cnt_r;

    logic       loadable;
    logic       sel_found;
    logic [1:0] sel_idx;
    logic [1:0] cand;
    logic [3:0] drain;
    logic [3:0] capture;
    logic [3:0] drop;
    logic [2:0] drop_num;
    logic [8:0] drop_sum;
    logic [7:0] drop_cnt_next;

    assign lane_valid   = {bus.valid_3, bus.valid_2, bus.valid_1, bus.valid_0};
    assign lane_data[0] = bus.data_0;
    assign lane_data[1] = bus.data_1;
    assign lane_data[2] = bus.data_2;
    assign lane_data[3] = bus.data_3;

    // The output register can take a new payload when it is empty or its
    // current payload is being consumed at this edge.
    assign loadable = !valid_out_r || bus.out_ready;

    // Round-robin search starting one past the last grant. The offset of 4
    // wraps back to ptr itself, so the last-granted lane is tried last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!sel_found && occ[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // A lane is drained only when the output stage can accept it. A lane
    // being drained can be refilled in the same cycle; an occupied lane that
    // is not drained loses the incoming payload.
    always_comb begin
        drain = 4'b0000;
        if (loadable && sel_found) begin
            drain[sel_idx] = 1'b1;
        end
        capture = lane_valid & (~occ | drain);
        drop    = lane_valid & occ & ~drain;
    end

    // Up to four drops can land in one cycle; the counter clamps at 255.
    always_comb begin
        drop_num      = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
        drop_sum      = {1'b0, drop_cnt_r} + 9'(drop_num);
        drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Lane holding registers and occupancy flags. Capture wins over drain
    // so a simultaneous drain and refill leaves the lane occupied.
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            occ <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                hold[n] <= 8'h00;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (capture[n]) begin
                    hold[n] <= lane_data[n];
                    occ[n]  <= 1'b1;
                end else if (drain[n]) begin
                    occ[n]  <= 1'b0;
                end
            end
        end
    end

    // Output stage and grant pointer. With nothing to load, valid_out drops
    // but data_out, grant and ptr keep their last values.
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            data_out_r  <= 8'h00;
            valid_out_r <= 1'b0;
            grant_r     <= 2'd0;
            ptr         <= 2'd3;
        end else if (loadable) begin
            if (sel_found) begin
                data_out_r  <= hold[sel_idx];
                valid_out_r <= 1'b1;
                grant_r     <= sel_idx;
                ptr         <= sel_idx;
            end else begin
                valid_out_r <= 1'b0;
            end
        end
    end

    // Drop counter.
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            drop_cnt_r <= 8'h00;
        end else begin
            drop_cnt_r <= drop_cnt_next;
        end
    end

    assign bus.data_out  = data_out_r;
    assign bus.valid_out = valid_out_r;
    assign bus.grant     = grant_r;
    assign bus.full_0    = occ[0];
    assign bus.full_1    = occ[1];
    assign bus.full_2    = occ[2];
    assign bus.full_3    = occ[3];
    assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lane_rr_arbiter
// Directed bench for lane_rr_arbiter: single lane latency, round-robin
// order, backpressure with multi-lane drops, drop counter saturation,
// same-cycle drain and refill, and asynchronous reset mid-stream.
// ---------------------------------------------------------------------------
module tb_lane_rr_arbiter;

    logic clk_f = 1'b0;
    logic reset_L;
    int   checks = 0;
    int   errors = 0;

    lane_rr_arbiter_if bus ();

    lane_rr_arbiter dut (
        .clk_f   (clk_f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    // Rising edges at 5, 15, 25, ...
    always #5 clk_f = ~clk_f;

    // Drive all lane inputs and out_ready in one go.
    task automatic apply_stimulus(input logic [3:0] valid,
                                  input logic [7:0] d0, input logic [7:0] d1,
                                  input logic [7:0] d2, input logic [7:0] d3,
                                  input logic ready);
        bus.valid_0   = valid[0];
        bus.valid_1   = valid[1];
        bus.valid_2   = valid[2];
        bus.valid_3   = valid[3];
        bus.data_0    = d0;
        bus.data_1    = d1;
        bus.data_2    = d2;
        bus.data_3    = d3;
        bus.out_ready = ready;
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] full_vec();
        return {bus.full_3, bus.full_2, bus.full_1, bus.full_0};
    endfunction

    // Pulse reset between edges, leaving inputs idle.
    task automatic do_reset();
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        reset_L = 1'b0;
        #2;
        reset_L = 1'b1;
    endtask

    logic [7:0] bp_data  [4] = '{8'h11, 8'h22, 8'h23, 8'h20};
    logic [1:0] bp_grant [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        // ---------------- reset state ----------------
        reset_L = 1'b0;
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        #2;
        check_output("rst_data_out",  bus.data_out,  8'h00);
        check_output("rst_valid_out", bus.valid_out, 1'b0);
        check_output("rst_grant",     bus.grant,     2'd0);
        check_output("rst_full",      full_vec(),    4'b0000);
        check_output("rst_drop_cnt",  bus.drop_cnt,  8'h00);
        #1;
        reset_L = 1'b1;

        // ---------------- single lane ----------------
        $display("[TB] single lane");
        apply_stimulus(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1);
        tick();
        check_output("sl_full_after_capture", full_vec(),    4'b0100);
        check_output("sl_valid_not_yet",      bus.valid_out, 1'b0);
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        check_output("sl_data_out",  bus.data_out,  8'hA5);
        check_output("sl_valid_out", bus.valid_out, 1'b1);
        check_output("sl_grant",     bus.grant,     2'd2);
        check_output("sl_full_clr",  full_vec(),    4'b0000);
        tick();
        check_output("sl_idle_valid", bus.valid_out, 1'b0);
        check_output("sl_idle_data",  bus.data_out,  8'hA5);
        check_output("sl_idle_grant", bus.grant,     2'd2);

        // ---------------- round-robin ----------------
        $display("[TB] round robin");
        do_reset();
        apply_stimulus(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1);
        tick();
        check_output("rr_full_all", full_vec(),    4'b1111);
        check_output("rr_valid_0",  bus.valid_out, 1'b0);
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output($sformatf("rr_data_%0d", i),  bus.data_out,  8'h10 + i);
            check_output($sformatf("rr_grant_%0d", i), bus.grant,     i);
            check_output($sformatf("rr_valid_%0d", i), bus.valid_out, 1'b1);
        end
        tick();
        check_output("rr_done_valid", bus.valid_out, 1'b0);

        // ---------------- backpressure and multi-lane drops ----------------
        $display("[TB] backpressure");
        do_reset();
        apply_stimulus(4'b0011, 8'h10, 8'h11, 8'h00, 8'h00, 1'b0);
        tick();
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        check_output("bp_first_data",  bus.data_out,  8'h10);
        check_output("bp_first_grant", bus.grant,     2'd0);
        check_output("bp_first_full",  full_vec(),    4'b0010);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output($sformatf("bp_hold_data_%0d", i),  bus.data_out,  8'h10);
            check_output($sformatf("bp_hold_valid_%0d", i), bus.valid_out, 1'b1);
            check_output($sformatf("bp_hold_full1_%0d", i), bus.full_1,    1'b1);
        end
        apply_stimulus(4'b1111, 8'h20, 8'hEE, 8'h22, 8'h23, 1'b0);
        tick();
        check_output("bp_drop_one",  bus.drop_cnt, 8'd1);
        check_output("bp_full_all",  full_vec(),   4'b1111);
        apply_stimulus(4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        tick();
        check_output("bp_drop_four", bus.drop_cnt, 8'd5);
        check_output("bp_data_held", bus.data_out, 8'h10);
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output($sformatf("bp_rel_data_%0d", i),  bus.data_out, bp_data[i]);
            check_output($sformatf("bp_rel_grant_%0d", i), bus.grant,    bp_grant[i]);
        end
        tick();
        check_output("bp_done_valid", bus.valid_out, 1'b0);

        // ---------------- drop counter saturation ----------------
        $display("[TB] drop saturation");
        do_reset();
        apply_stimulus(4'b0001, 8'h55, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        check_output("sat_out_data", bus.data_out, 8'h55);
        apply_stimulus(4'b0001, 8'h66, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        check_output("sat_full0",    bus.full_0,   1'b1);
        check_output("sat_drop_0",   bus.drop_cnt, 8'd0);
        apply_stimulus(4'b0001, 8'h99, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        check_output("sat_drop_1",   bus.drop_cnt, 8'd1);
        repeat (9) tick();
        check_output("sat_drop_10",  bus.drop_cnt, 8'd10);
        repeat (290) tick();
        check_output("sat_drop_255", bus.drop_cnt, 8'd255);
        check_output("sat_data_held", bus.data_out, 8'h55);
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        check_output("sat_first_payload", bus.data_out, 8'h66);
        check_output("sat_grant",         bus.grant,    2'd0);
        check_output("sat_drop_stays",    bus.drop_cnt, 8'd255);
        tick();
        check_output("sat_done_valid", bus.valid_out, 1'b0);

        // ---------------- drain and refill ----------------
        $display("[TB] drain and refill");
        do_reset();
        apply_stimulus(4'b1001, 8'h30, 8'h00, 8'h00, 8'h33, 1'b1);
        tick();
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        check_output("dr_first_data", bus.data_out, 8'h30);
        check_output("dr_full",       full_vec(),   4'b1000);
        apply_stimulus(4'b1000, 8'h00, 8'h00, 8'h00, 8'h7E, 1'b1);
        tick();
        check_output("dr_lane3_data",  bus.data_out, 8'h33);
        check_output("dr_lane3_grant", bus.grant,    2'd3);
        check_output("dr_full3_kept",  bus.full_3,   1'b1);
        check_output("dr_no_drop",     bus.drop_cnt, 8'd0);
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        check_output("dr_refill_data",  bus.data_out, 8'h7E);
        check_output("dr_refill_grant", bus.grant,    2'd3);
        check_output("dr_full3_clr",    bus.full_3,   1'b0);

        // ---------------- async reset mid-stream ----------------
        $display("[TB] async reset");
        apply_stimulus(4'b1111, 8'h50, 8'h51, 8'h52, 8'h53, 1'b0);
        tick();
        apply_stimulus(4'b0010, 8'h00, 8'hEE, 8'h00, 8'h00, 1'b0);
        tick();
        check_output("ar_pre_valid", bus.valid_out, 1'b1);
        check_output("ar_pre_drop",  bus.drop_cnt,  8'd1);
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        check_output("ar_data_out",  bus.data_out,  8'h00);
        check_output("ar_valid_out", bus.valid_out, 1'b0);
        check_output("ar_grant",     bus.grant,     2'd0);
        check_output("ar_full",      full_vec(),    4'b0000);
        check_output("ar_drop_cnt",  bus.drop_cnt,  8'h00);
        #1;
        reset_L = 1'b1;
        apply_stimulus(4'b0011, 8'h40, 8'h41, 8'h00, 8'h00, 1'b1);
        tick();
        check_output("ar_post_full", full_vec(), 4'b0011);
        apply_stimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        check_output("ar_post_data0",  bus.data_out, 8'h40);
        check_output("ar_post_grant0", bus.grant,    2'd0);
        tick();
        check_output("ar_post_data1",  bus.data_out, 8'h41);
        check_output("ar_post_grant1", bus.grant,    2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_rr_arbiter.md
LANE_RR_ARBITER -- requirements
Module: lane_rr_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset:
- clk_f  in  1: single rising-edge clock; all state updates on it.
- reset_L  in  1: asynchronous, active-low reset.
REQ-002 The block SHALL have these data and handshake ports:
- data_0, data_1, data_2, data_3  in  8 each: lane payloads.
- valid_0, valid_1, valid_2, valid_3  in  1 each: lane N payload present this cycle.
- out_ready  in  1: downstream accepts data_out this cycle.
- data_out  out  8: scheduled payload, registered.
- valid_out  out  1: data_out holds an undelivered payload, registered.
- grant  out  2: lane index of the payload currently in data_out, registered.
- full_0, full_1, full_2, full_3  out  1 each: lane N holding register occupied, registered.
- drop_cnt  out  8: count of discarded lane payloads, registered.

Function
REQ-003 Each lane SHALL own a 1-entry holding register (hold_N, 8 bits) with an occupancy flag occ_N, and full_N SHALL equal occ_N.
REQ-004 The output stage SHALL be "loadable" in a cycle when valid_out=0 or out_ready=1.
REQ-005 In a loadable cycle with at least one occ_N=1, the arbiter SHALL select a lane round-robin, searching from lane (ptr+1) mod 4 upward with wrap, where ptr is a 2-bit last-granted pointer.
REQ-006 On selection of lane K:
- data_out <= hold_K, valid_out <= 1, grant <= K, ptr <= K.
- occ_K is cleared unless lane K is refilled in the same cycle (REQ-008).
REQ-007 In a loadable cycle with no occupied lane, valid_out SHALL go to 0, while data_out, grant and ptr SHALL hold their values.
REQ-008 Lane N SHALL capture data_N into hold_N with occ_N <= 1 when valid_N=1 and either occ_N=0 or lane N is selected in that same cycle. Simultaneous drain and refill keeps occ_N=1 with the new payload.
REQ-009 When valid_N=1, occ_N=1 and lane N is not selected that cycle:
- the payload SHALL be discarded;
- hold_N SHALL be unchanged;
- drop_cnt SHALL increment by the number of lanes dropping that cycle (0..4), saturating at 255.
REQ-010 When the output stage is not loadable (valid_out=1, out_ready=0), data_out, valid_out, grant and ptr SHALL hold, and no lane SHALL be drained.
REQ-011 Minimum latency SHALL be 2 cycles: payload sampled at edge t into hold_N, presented on data_out after edge t+1, given an empty output stage and no competing lanes.
REQ-012 Under continuous out_ready=1 with all four lanes occupied, grants SHALL cycle 0,1,2,3,0,... with one payload delivered per cycle and no lane starved longer than 3 cycles.
REQ-013 A payload SHALL be delivered exactly once: it is consumed when valid_out=1 and out_ready=1 at a rising edge.
REQ-014 Payload bits SHALL pass unmodified; no arithmetic is applied to data.

Reset
REQ-015 While reset_L=0, asynchronously and independent of clk_f, the block SHALL force:
- data_out=8'h00, valid_out=0, grant=2'd0;
- all occ_N=0 (full_N=0), all hold_N=8'h00;
- drop_cnt=8'h00, ptr=2'd3 (lane 0 has first priority after reset).
REQ-016 Reset asserted mid-operation SHALL discard all held and output payloads without delivering them. The first edge after reset_L rises SHALL behave as a normal cycle from the reset state.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Single lane: reset, then valid_2=1, data_2=8'hA5 for one cycle, out_ready=1 -> two edges later data_out=8'hA5, valid_out=1, grant=2; full_2=1 only between the two edges.
- Round-robin: all four lanes loaded with 8'h10, 8'h11, 8'h12, 8'h13 in the same cycle, out_ready=1 -> data_out 8'h10, 8'h11, 8'h12, 8'h13 on consecutive cycles, grant 0,1,2,3, then valid_out=0.
- Backpressure: out_ready=0 with valid_out=1, data_out=8'h10 held 5 cycles while lane 1 holds 8'h11 -> data_out stays 8'h10 and full_1 stays 1; on out_ready=1, 8'h11 appears next cycle.
- Drop/saturation: lane 0 held by backpressure while valid_0=1 for 300 cycles -> drop_cnt counts up and stops at 255; hold_0 keeps its first payload.
- Drain+refill: lane 3 occupied and selected in the same cycle valid_3=1, data_3=8'h7E -> full_3 stays 1, no drop, 8'h7E delivered at lane 3's next grant.
- Async reset mid-stream: reset_L pulled low between clock edges with lanes full -> all outputs zero immediately, without waiting for a clk_f edge; first post-reset grant goes to lane 0 when lanes 0 and 1 request together.
